serial_adder_ctrl: RTL and testbench

Bit-serial add controller. It time-multiplexes one full-adder cell, built from two half_adder instances plus an OR, across the bits of two W-bit operands, producing one sum bit per clock. Operands are accepted on a valid/ready handshake and the result is returned on a second valid/ready handshake. A saturating count of completed operations is kept for debug. The block sits between an operand source and a result sink wherever area matters more than latency.

---
 rtl/serial_adder_ctrl_if.sv | 23 ++
 rtl/serial_adder_ctrl.sv | 116 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand and result handshake bundle between the source/sink side and the bit-serial adder.
interface serial_adder_ctrl_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: one shared full-adder cell, one sum bit per clock.
// Latency: result valid the cycle after the W-th RUN edge; one operation per W+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_adder_ctrl_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);
    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  sum_sr;
    logic [W-1:0]  sum_shift;
    logic          carry;
    logic [CW-1:0] bit_cnt;
    logic          ha0_s;
    logic          ha0_c;
    logic          ha1_s;
    logic          ha1_c;
    logic          carry_nxt;

    half_adder u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.a(ha0_s),   .b(carry),   .s(ha1_s), .c(ha1_c));
    assign carry_nxt = ha0_c | ha1_c;

    // New sum bit enters at the MSB so the LSB-first result lands in place after W shifts.
    always_comb begin
        sum_shift        = sum_sr >> 1;
        sum_shift[W-1]   = ha1_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)    state_nxt = RUN;
            RUN:     if (bit_cnt == LAST) state_nxt = DONE;
            DONE:    if (bus.out_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            op_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr    <= bus.in_a;
                        b_sr    <= bus.in_b;
                        sum_sr  <= '0;
                        carry   <= 1'b0;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_shift;
                    carry   <= carry_nxt;
                    bit_cnt <= bit_cnt + CW'(1);
                end
                DONE: begin
                    if (bus.out_ready && (op_cnt != {CNT_W{1'b1}})) begin
                        op_cnt <= op_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign busy          = (state == RUN);
    assign bus.out_sum   = sum_sr;
    assign bus.out_carry = carry;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes a+b at acceptance, monitor pops on each result.
module tb_serial_adder_ctrl;
    localparam int W     = 8;
    localparam int CNT_W = 16;

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;
    logic             hold = 1'b0;
    logic             rand_stall = 1'b0;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   run_len = 0;
    logic prev_ov = 1'b0;
    logic have_hold = 1'b0;
    logic [W:0] held;
    exp_t q[$];

    serial_adder_ctrl_if #(.W(W)) bus ();

    serial_adder_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = hold ? 1'b0 : (rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits for IDLE, presents the operands, and records the expected sum at the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push, input bit toggle);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = toggle ? W'($urandom) : a;
        bus.in_b = toggle ? W'($urandom) : b;
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            if (toggle) begin
                bus.in_a = W'($urandom);
                bus.in_b = W'($urandom);
            end
            t++;
        end
        if (t >= 500) begin
            check("send_timeout", t, 0);
            bus.in_valid = 1'b0;
            return;
        end
        bus.in_a = a;
        bus.in_b = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) q.push_back('{res: {1'b0, a} + {1'b0, b}, acc: cyc});
        check("in_ready_after_accept", bus.in_ready, 0);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic drain(input int exp_cnt);
        int t = 0;
        @(negedge clk);
        while ((q.size() != 0 || !bus.in_ready) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", t < 1000, 1);
        check("op_cnt", op_cnt, exp_cnt);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            done_cnt  = 0;
            run_len   = 0;
            prev_ov   = 1'b0;
            have_hold = 1'b0;
        end else begin
            check("state_onehot", {bus.in_ready, busy, bus.out_valid} inside {3'b100, 3'b010, 3'b001}, 1);
            check("op_cnt_track", op_cnt, done_cnt);
            if (busy) begin
                run_len++;
            end else if (run_len != 0) begin
                check("run_length", run_len, W);
                run_len = 0;
            end
            if (bus.out_valid) begin
                check("result_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    if (!prev_ov) check("latency", cyc - q[0].acc, W);
                    if (have_hold) check("held_stable", {bus.out_carry, bus.out_sum}, held);
                    if (bus.out_ready) begin
                        check("sum", {bus.out_carry, bus.out_sum}, q[0].res);
                        void'(q.pop_front());
                        done_cnt++;
                        have_hold = 1'b0;
                    end else begin
                        have_hold = 1'b1;
                        held = {bus.out_carry, bus.out_sum};
                    end
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        int edges;
        int t;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_op_cnt", op_cnt, 0);
        check("rst_out_sum", {bus.out_carry, bus.out_sum}, 0);

        send(8'hFF, 8'h01, 1, 0);
        drain(1);

        send(8'hA5, 8'h5A, 1, 0);
        send(8'h80, 8'h80, 1, 0);
        drain(3);

        // Sink stalls for 5 result cycles.
        hold = 1'b1;
        send(8'h3C, 8'h0F, 1, 0);
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_sum", {bus.out_carry, bus.out_sum}, 9'h04B);
            @(negedge clk);
        end
        hold = 1'b0;
        edges = 0;
        while (!bus.in_ready && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("bp_release_edges", edges, 2);
        drain(4);

        // Reset in the 4th RUN cycle of 0xFF+0xFF.
        send(8'hFF, 8'hFF, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_op_cnt", op_cnt, 0);
        send(8'h01, 8'h02, 1, 0);
        drain(1);

        // Operands wiggle while the previous op runs; only the value at acceptance counts.
        send(8'h12, 8'h34, 1, 0);
        send(8'h55, 8'h22, 1, 1);
        drain(3);

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_stall = 1'b1;
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(W'($urandom), W'($urandom), 1, ($urandom_range(0, 3) == 0));
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
